// File: rtl/intr_context_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intr_context_ctrl_pkg
// Description : Shared definitions for the interrupt context controller:
//               default address width, controller state encoding and the
//               well-known ISR vector addresses.
// Revision    : 1.0 - initial release
// ============================================================================
package intr_context_ctrl_pkg;

    localparam int c_ADDR_W_DEFAULT = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_ISR    = 2'd2,
        ST_RETURN = 2'd3
    } state_t;

    localparam logic [9:0] c_VEC_TIMER     = 10'h013;
    localparam logic [9:0] c_VEC_EXCEPTION = 10'h3FB;
    localparam logic [9:0] c_VEC_PORT      = 10'h3FC;
    localparam logic [9:0] c_VEC_SYSCALL   = 10'h3FD;

endpackage
`default_nettype wire

// File: rtl/intr_ret_stack.sv
`default_nettype none
// ============================================================================
// Module      : intr_ret_stack
// Description : LIFO holding interrupt return addresses.
//   clk, reset  : clock, synchronous active-high reset (empties the stack)
//   push        : write push_data on top (ignored when full)
//   pop         : discard top entry (ignored when empty)
//   top         : current top entry, 0 when empty
//   count       : number of valid entries
//   full, empty : occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module intr_ret_stack #(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = 10,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_do_push;
    logic              w_do_pop;

    assign w_wr_idx  = IDX_W'(r_count);
    assign w_rd_idx  = IDX_W'(r_count - 1'b1);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push && !full;
    // Push has priority so a simultaneous push/pop can never corrupt count.
    assign w_do_pop  = pop && !empty && !w_do_push;

    // Storage carries no reset: validity is tracked solely by r_count.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_do_push) begin
            r_count <= r_count + 1'b1;
        end else if (w_do_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign top   = empty ? '0 : r_mem[w_rd_idx];
    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/intr_context_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intr_context_ctrl
// Description : Interrupt entry/return sequencer. Detects interrupt requests,
//               saves the return address on a nesting stack, redirects the
//               core to the ISR vector and back on return-from-interrupt.
//   clk, reset     : clock, synchronous active-high reset
//   s_interruption : interrupt request (rising edge = new request)
//   dir_in         : ISR vector, sampled on the request edge
//   pc_next        : return address candidate from the core
//   i_reti         : return-from-interrupt decoded this cycle
//   pc_sel         : registered; 1 = core loads pc_target
//   pc_target      : registered redirect address
//   s_finished     : registered one-cycle pulse on ISR completion
//   in_isr, depth  : nesting status
//   err_ovf/err_unf: sticky overflow / underflow flags
// Revision    : 1.0 - initial release
// ============================================================================
module intr_context_ctrl
    import intr_context_ctrl_pkg::*;
#(
    parameter  int ADDR_W = c_ADDR_W_DEFAULT,
    parameter  int DEPTH  = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_interruption,
    input  logic [ADDR_W-1:0] dir_in,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              i_reti,
    output logic              pc_sel,
    output logic [ADDR_W-1:0] pc_target,
    output logic              s_finished,
    output logic              in_isr,
    output logic [CNT_W-1:0]  depth,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam logic [1:0] c_IDLE   = ST_IDLE;
    localparam logic [1:0] c_ENTER  = ST_ENTER;
    localparam logic [1:0] c_ISR    = ST_ISR;
    localparam logic [1:0] c_RETURN = ST_RETURN;

    logic [1:0]        r_state;
    logic              r_s_int_d;
    logic              r_pending;
    logic [ADDR_W-1:0] r_vec;
    logic              r_pc_sel;
    logic [ADDR_W-1:0] r_pc_target;
    logic              r_s_finished;
    logic              r_err_ovf;
    logic              r_err_unf;

    logic [1:0]        w_next_state;
    logic              w_rise;
    logic              w_push;
    logic              w_pop;
    logic              w_take;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic [ADDR_W-1:0] w_top;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;

    assign w_rise = s_interruption && !r_s_int_d;

    intr_ret_stack #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ret_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (pc_next),
        .top       (w_top),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

    always_comb begin
        w_next_state = r_state;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_take       = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (i_reti) begin
                    w_set_unf = 1'b1;
                end
                if (r_pending) begin
                    w_take = 1'b1;
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_push       = 1'b1;
                        w_next_state = c_ENTER;
                    end
                end
            end
            c_ENTER: begin
                w_next_state = c_ISR;
            end
            c_ISR: begin
                // Return wins over a pending request; the request stays
                // pending and is serviced after the RETURN cycle.
                if (i_reti) begin
                    w_pop        = !w_empty;
                    w_next_state = c_RETURN;
                end else if (r_pending) begin
                    w_take = 1'b1;
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_push       = 1'b1;
                        w_next_state = c_ENTER;
                    end
                end
            end
            c_RETURN: begin
                // w_count already reflects the pop done on entry to RETURN.
                w_next_state = (w_count != '0) ? c_ISR : c_IDLE;
            end
            default: begin
                w_next_state = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_s_int_d    <= 1'b0;
            r_pending    <= 1'b0;
            r_vec        <= '0;
            r_pc_sel     <= 1'b0;
            r_pc_target  <= '0;
            r_s_finished <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_err_unf    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_s_int_d <= s_interruption;

            // A fresh edge re-arms pending even on the edge that consumes the
            // previous request, so back-to-back requests are not lost.
            if (w_rise) begin
                r_pending <= 1'b1;
                r_vec     <= dir_in;
            end else if (w_take) begin
                r_pending <= 1'b0;
            end

            r_pc_sel     <= (w_next_state == c_ENTER) || (w_next_state == c_RETURN);
            r_s_finished <= (w_next_state == c_RETURN);

            if (w_push) begin
                r_pc_target <= r_vec;
            end else if (w_pop) begin
                r_pc_target <= w_top;
            end

            if (w_set_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (w_set_unf) begin
                r_err_unf <= 1'b1;
            end
        end
    end

    assign pc_sel     = r_pc_sel;
    assign pc_target  = r_pc_target;
    assign s_finished = r_s_finished;
    assign depth      = w_count;
    assign in_isr     = (w_count != '0);
    assign err_ovf    = r_err_ovf;
    assign err_unf    = r_err_unf;

endmodule
`default_nettype wire
